// File: rtl/pe_pkg.sv
// pe_pkg: shared types and constants for the PE result drain.
package pe_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      ACCUM = 2'd2,
      DRAIN = 2'd3
   } state_t;

   // PE input-to-output offset minus the sampling edge; loaded as the FILL count
   localparam int PIPE_LAT   = 2;
   localparam int DEFAULT_BW = 8;

endpackage

// File: rtl/pe_snapshot_bank.sv
// pe_snapshot_bank: N_PE x W register bank, loaded all at once, read one word at a time.
module pe_snapshot_bank #(
   parameter int N_PE = 4,
   parameter int W    = 16,
   localparam int IDX_W = (N_PE > 1) ? $clog2(N_PE) : 1
)(
   input  logic              i_clock,
   input  logic              i_reset_n,
   input  logic              i_load,
   input  logic [N_PE*W-1:0] i_data,
   input  logic [IDX_W-1:0]  i_rd_idx,
   output logic [W-1:0]      o_rd_data
);

   logic [W-1:0] bank_r [N_PE];
   logic [W-1:0] rd_data_s;

   // Capture every PE word in the same cycle
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int k = 0; k < N_PE; k++) begin
            bank_r[k] <= '0;
         end
      end else if (i_load) begin
         for (int k = 0; k < N_PE; k++) begin
            bank_r[k] <= i_data[k*W +: W];
         end
      end
   end

   // Read mux; an out-of-range index reads zero
   always_comb begin
      rd_data_s = '0;
      for (int k = 0; k < N_PE; k++) begin
         rd_data_s = (i_rd_idx == IDX_W'(k)) ? bank_r[k] : rd_data_s;
      end
   end

   assign o_rd_data = rd_data_s;

endmodule

// File: rtl/pe_result_drain.sv
// pe_result_drain: snapshots a PE row before and after each tile and streams per-PE deltas.
// Optional macro PE_DRAIN_START_ERR_EN adds the sticky o_start_err port.
module pe_result_drain
   import pe_pkg::*;
#(
   parameter int BW    = DEFAULT_BW,
   parameter int N_PE  = 4,
   parameter int LEN_W = 8,
   localparam int RW    = 2*BW,
   localparam int IDX_W = (N_PE > 1) ? $clog2(N_PE) : 1
)(
   input  logic               i_clock,
   input  logic               i_reset_n,
   input  logic [N_PE*RW-1:0] i_pe_results,
   input  logic               i_start,
   input  logic [LEN_W-1:0]   i_len,
   output logic               o_busy,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [RW-1:0]      o_data,
   output logic [IDX_W-1:0]   o_index,
`ifdef PE_DRAIN_START_ERR_EN
   output logic               o_start_err,
`endif
   output logic               o_last
);

   localparam int CNT_W = (LEN_W > 2) ? LEN_W : 2;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [LEN_W-1:0] len_r;
   logic [IDX_W-1:0] idx_r;
   logic             cnt_expire_s;
   logic             busy_s;
   logic             valid_s;
   logic             last_s;
   logic             xfer_s;
   logic             base_load_s;
   logic             final_load_s;
   logic [RW-1:0]    base_word_s;
   logic [RW-1:0]    final_word_s;

   assign cnt_expire_s = (cnt_r <= CNT_W'(1));
   assign xfer_s       = valid_s && i_ready;

   // State register
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; i_start only matters in IDLE
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (i_start) state_nxt_s = FILL;
            else         state_nxt_s = IDLE;
         end
         FILL: begin
            if (cnt_expire_s) state_nxt_s = (len_r == '0) ? DRAIN : ACCUM;
            else              state_nxt_s = FILL;
         end
         ACCUM: begin
            if (cnt_expire_s) state_nxt_s = DRAIN;
            else              state_nxt_s = ACCUM;
         end
         DRAIN: begin
            if (xfer_s && last_s) state_nxt_s = IDLE;
            else                  state_nxt_s = DRAIN;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Output and load-enable decode; a zero-length tile loads both banks together
   always_comb begin
      busy_s       = (state_r != IDLE);
      valid_s      = (state_r == DRAIN);
      last_s       = valid_s && (idx_r == IDX_W'(N_PE - 1));
      base_load_s  = (state_r == FILL) && cnt_expire_s;
      final_load_s = ((state_r == FILL) || (state_r == ACCUM)) && cnt_expire_s;
   end

   // Tile length latch, wait counter and drain index
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         len_r <= '0;
         cnt_r <= '0;
         idx_r <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (i_start) begin
                  len_r <= i_len;
                  cnt_r <= CNT_W'(PIPE_LAT);
               end
            end
            FILL, ACCUM: begin
               if (cnt_expire_s) cnt_r <= CNT_W'(len_r);
               else              cnt_r <= cnt_r - CNT_W'(1);
            end
            DRAIN: begin
               if (xfer_s) idx_r <= last_s ? '0 : idx_r + IDX_W'(1);
            end
            default: begin
               cnt_r <= '0;
               idx_r <= '0;
            end
         endcase
      end
   end

   pe_snapshot_bank #(.N_PE(N_PE), .W(RW)) u_base_bank (
      .i_clock   (i_clock),
      .i_reset_n (i_reset_n),
      .i_load    (base_load_s),
      .i_data    (i_pe_results),
      .i_rd_idx  (idx_r),
      .o_rd_data (base_word_s)
   );

   pe_snapshot_bank #(.N_PE(N_PE), .W(RW)) u_final_bank (
      .i_clock   (i_clock),
      .i_reset_n (i_reset_n),
      .i_load    (final_load_s),
      .i_data    (i_pe_results),
      .i_rd_idx  (idx_r),
      .o_rd_data (final_word_s)
   );

`ifdef PE_DRAIN_START_ERR_EN
   logic start_err_r;

   // Sticky record of a start pulse that arrived while busy
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         start_err_r <= 1'b0;
      end else if (i_start && busy_s) begin
         start_err_r <= 1'b1;
      end
   end

   assign o_start_err = start_err_r;
`endif

   // Modular difference handles accumulator wrap inside a tile
   assign o_data  = final_word_s - base_word_s;
   assign o_busy  = busy_s;
   assign o_valid = valid_s;
   assign o_index = idx_r;
   assign o_last  = last_s;

endmodule
